// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write counters and an
// optional same-cycle write-back bypass for the decode/issue stage.
// x0 reads as zero and never becomes pending.
module regfile_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CW     = 2,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_ready,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic                sb_err
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] regs [NREG];
    logic [CW-1:0]   cnt  [NREG];
    logic [NREG-1:0] cnt_inc;
    logic [NREG-1:0] cnt_dec;
    logic            iss_acc;

    // Issue stalls only when the destination counter is saturated; wb is ignored here.
    assign iss_ready = (iss_rd == '0) || (cnt[iss_rd] != CNT_MAX);
    assign iss_acc   = iss_valid && iss_ready;

    // Per-register increment/decrement requests; entry 0 never changes.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_inc[r] = iss_acc && (iss_rd == AW'(r));
            cnt_dec[r] = wb_valid && (wb_rd == AW'(r)) && (cnt[r] != '0);
        end
    end

    // Register storage, pending counters and sticky scoreboard error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wb_valid && (wb_rd != '0)) begin
                regs[wb_rd] <= wb_data;
                if (cnt[wb_rd] == '0) begin
                    sb_err <= 1'b1;
                end
            end
            for (int r = 1; r < NREG; r++) begin
                if (cnt_inc[r] && !cnt_dec[r]) begin
                    cnt[r] <= cnt[r] + CW'(1);
                end else if (cnt_dec[r] && !cnt_inc[r]) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    // Combinational read ports with optional forwarding of this cycle's write-back.
    always_comb begin
        logic [AW-1:0] a;
        logic          wb_hit;
        a        = '0;
        wb_hit   = 1'b0;
        rs_data  = '0;
        rs_ready = '0;
        for (int k = 0; k < NRD; k++) begin
            a      = rs_addr[k*AW +: AW];
            wb_hit = (BYPASS != 0) && wb_valid && (wb_rd == a);
            if (a == '0) begin
                rs_data[k*XLEN +: XLEN] = '0;
                rs_ready[k]             = 1'b1;
            end else if (wb_hit) begin
                rs_data[k*XLEN +: XLEN] = wb_data;
                rs_ready[k]             = (cnt[a] <= CW'(1));
            end else begin
                rs_data[k*XLEN +: XLEN] = regs[a];
                rs_ready[k]             = (cnt[a] == '0);
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: one bypassing and one non-bypassing instance share stimulus;
// expectations are queued per cycle and checked mid-cycle by a monitor.
module tb_regfile_scoreboard;

    localparam int unsigned AW = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  rs_addr;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [63:0] byp_rs_data, nob_rs_data;
    logic [1:0]  byp_rs_ready, nob_rs_ready;
    logic        byp_iss_ready, nob_iss_ready;
    logic        byp_sb_err, nob_sb_err;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1), .CW(2)) u_byp (
        .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rs_data(byp_rs_data),
        .rs_ready(byp_rs_ready), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_ready(byp_iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .sb_err(byp_sb_err)
    );

    regfile_scoreboard #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0), .CW(2)) u_nob (
        .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rs_data(nob_rs_data),
        .rs_ready(nob_rs_ready), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_ready(nob_iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .sb_err(nob_sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          dut;   // 0 = bypass instance, 1 = no-bypass instance
        int          sel;   // 0 data0, 1 data1, 2 rs_ready, 3 iss_ready, 4 sb_err
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int dut, input int sel);
        logic [63:0] d;
        logic [1:0]  r;
        logic        ir, se;
        d  = (dut == 0) ? byp_rs_data   : nob_rs_data;
        r  = (dut == 0) ? byp_rs_ready  : nob_rs_ready;
        ir = (dut == 0) ? byp_iss_ready : nob_iss_ready;
        se = (dut == 0) ? byp_sb_err    : nob_sb_err;
        case (sel)
            0:       return d[31:0];
            1:       return d[63:32];
            2:       return {30'b0, r};
            3:       return {31'b0, ir};
            default: return {31'b0, se};
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] got;
            e   = q.pop_front();
            got = actual(e.dut, e.sel);
            checks++;
            if (e.cyc != cyc || got !== e.exp) begin
                failures++;
                $display("FAIL %s dut=%s cyc=%0d got=%h exp=%h", e.name,
                         (e.dut == 0) ? "bypass" : "nobypass", cyc, got, e.exp);
            end
        end
    end

    task automatic chk(input string name, input int dut, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.dut = dut; e.sel = sel; e.exp = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic chk2(input string name, input int sel, input logic [31:0] v);
        chk(name, 0, sel, v);
        chk(name, 1, sel, v);
    endtask

    task automatic drv(input logic iv, input logic [4:0] ird, input logic wv,
                       input logic [4:0] wrd, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1);
        iss_valid = iv; iss_rd = ird; wb_valid = wv; wb_rd = wrd; wb_data = wd;
        rs_addr = {a1, a0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drv(0, 0, 0, 0, 0, 5, 9);
        step();
        // Reset held
        chk2("rst_data0", 0, 0); chk2("rst_ready", 2, 3);
        chk2("rst_iss_ready", 3, 1); chk2("rst_sb_err", 4, 0);
        step();
        reset_n = 1'b1;
        step();

        // x0 issue and write-back are no-ops
        drv(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        chk2("x0_iss_ready", 3, 1); chk2("x0_data_wb", 0, 0); chk2("x0_ready", 2, 3);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk2("x0_sb_err", 4, 0); chk2("x0_data_after", 0, 0);
        step();

        // RAW on x7
        drv(1, 7, 0, 0, 0, 7, 0);
        chk2("raw_ready_iss_cycle", 2, 3);
        step();
        drv(0, 0, 0, 0, 0, 7, 0);
        chk2("raw_ready_pending", 2, 2);
        step();
        drv(0, 0, 1, 7, 32'h12345678, 7, 7);
        chk("raw_wb_data0", 0, 0, 32'h12345678); chk("raw_wb_data1", 0, 1, 32'h12345678);
        chk("raw_wb_ready", 0, 2, 3);
        chk("raw_wb_data0", 1, 0, 0); chk("raw_wb_ready", 1, 2, 0);
        step();
        drv(0, 0, 0, 0, 0, 7, 0);
        chk2("raw_after_data", 0, 32'h12345678); chk2("raw_after_ready", 2, 3);
        step();

        // Multiple outstanding writes on x3, saturation at 3
        for (int i = 0; i < 3; i++) begin
            drv(1, 3, 0, 0, 0, 3, 0);
            chk2("x3_iss_ready_fill", 3, 1);
            step();
        end
        drv(0, 3, 0, 0, 0, 3, 0);
        chk2("x3_iss_ready_sat", 3, 0); chk2("x3_ready_sat", 2, 2);
        step();
        drv(0, 4, 0, 0, 0, 3, 0);
        chk2("x4_iss_ready", 3, 1);
        step();
        drv(0, 3, 1, 3, 32'd1, 3, 0);
        chk2("x3_iss_ready_wb_cycle", 3, 0); chk2("x3_ready_cnt3_wb", 2, 2);
        step();
        drv(0, 3, 0, 0, 0, 3, 0);
        chk2("x3_iss_ready_cnt2", 3, 1); chk2("x3_ready_cnt2", 2, 2);
        step();
        drv(1, 3, 1, 3, 32'd2, 3, 0);
        chk2("x3_iss_ready_both", 3, 1); chk2("x3_ready_both", 2, 2);
        chk("x3_data_both", 0, 0, 32'd2); chk("x3_data_both", 1, 0, 32'd1);
        step();
        drv(0, 3, 0, 0, 0, 3, 0);
        chk2("x3_data_after_both", 0, 32'd2); chk2("x3_ready_after_both", 2, 2);
        step();
        drv(0, 3, 1, 3, 32'd3, 3, 0);
        chk("x3_ready_wb_cnt2", 0, 2, 2); chk("x3_ready_wb_cnt2", 1, 2, 2);
        step();
        drv(0, 3, 0, 0, 0, 3, 0);
        chk2("x3_ready_cnt1", 2, 2);
        step();
        drv(0, 3, 1, 3, 32'd4, 3, 0);
        chk("x3_ready_wb_cnt1", 0, 2, 3); chk("x3_data_wb_cnt1", 0, 0, 32'd4);
        chk("x3_ready_wb_cnt1", 1, 2, 2); chk("x3_data_wb_cnt1", 1, 0, 32'd3);
        step();
        drv(0, 3, 0, 0, 0, 3, 0);
        chk2("x3_ready_drained", 2, 3); chk2("x3_data_drained", 0, 32'd4);
        chk2("x3_sb_err", 4, 0);
        step();

        // Write-back with no pending write on x9
        drv(0, 9, 1, 9, 32'hA5A5A5A5, 9, 7);
        chk2("err_sb_err_wb_cycle", 4, 0); chk2("err_ready_wb", 2, 3);
        chk("err_data_wb", 0, 0, 32'hA5A5A5A5); chk("err_data_wb", 1, 0, 0);
        chk2("err_data1_x7", 1, 32'h12345678);
        step();
        drv(0, 9, 0, 0, 0, 9, 7);
        chk2("err_sb_err_set", 4, 1); chk2("err_data_after", 0, 32'hA5A5A5A5);
        chk2("err_ready_after", 2, 3);
        step();
        drv(1, 9, 0, 0, 0, 9, 0);
        chk2("err_iss_ready_x9", 3, 1); chk2("err_ready_iss", 2, 3);
        step();
        drv(0, 9, 0, 0, 0, 9, 0);
        chk2("err_ready_pending", 2, 2); chk2("err_sb_err_sticky", 4, 1);
        step();
        drv(0, 9, 1, 9, 32'h5A5A5A5A, 9, 0);
        chk2("err_sb_err_sticky_wb", 4, 1);
        chk("err_ready_wb2", 0, 2, 3); chk("err_ready_wb2", 1, 2, 2);
        step();
        drv(0, 9, 0, 0, 0, 9, 0);
        chk2("err_ready_final", 2, 3); chk2("err_data_final", 0, 32'h5A5A5A5A);
        step();

        // Build cnt[5]=2, regs[5]=DEADBEEF, then reset mid-run
        drv(1, 5, 0, 0, 0, 5, 9); step();
        drv(0, 5, 1, 5, 32'hDEADBEEF, 5, 9); step();
        drv(1, 5, 0, 0, 0, 5, 9); step();
        drv(1, 5, 0, 0, 0, 5, 9); step();
        drv(0, 5, 0, 0, 0, 5, 9);
        chk2("pre_rst_data0", 0, 32'hDEADBEEF); chk2("pre_rst_data1", 1, 32'h5A5A5A5A);
        chk2("pre_rst_ready", 2, 2); chk2("pre_rst_iss_ready", 3, 1);
        chk2("pre_rst_sb_err", 4, 1);
        step();
        reset_n = 1'b0;
        chk2("mid_rst_data0", 0, 0); chk2("mid_rst_data1", 1, 0);
        chk2("mid_rst_ready", 2, 3); chk2("mid_rst_sb_err", 4, 0);
        chk2("mid_rst_iss_ready", 3, 1);
        step();
        reset_n = 1'b1;
        chk2("post_rst_data0", 0, 0); chk2("post_rst_ready", 2, 3);
        chk2("post_rst_sb_err", 4, 0);
        step();
        step();

        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_expectations got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file with a per-register pending-write scoreboard and an optional write-back bypass, for the pipelined core's decode/issue stage. Any number of combinational read ports; one write-back port. Issue marks a destination register pending and write-back clears it, so decode can stall on RAW hazards without a separate hazard unit. x0 reads as zero and is never pending.

## Interface
- XLEN, 32: data width.
- NREG, 32: register count, power of two, ≥2; AW = clog2(NREG).
- NRD, 2: number of read ports.
- BYPASS, 1: 1 = same-cycle write-back data forwarded to read ports; 0 = no forwarding.
- CW, 2: pending-counter width; at most 2^CW−1 outstanding writes per register.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rs_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN].
- rs_ready  out  NRD  1 = port k operand has no outstanding write (or is bypassed).
- iss_valid  in  1  instruction issuing with destination iss_rd.
- iss_rd  in  AW  destination register of issuing instruction.
- iss_ready  out  1  0 = iss_rd pending counter saturated; issue must stall.
- wb_valid  in  1  write-back strobe.
- wb_rd  in  AW  write-back destination.
- wb_data  in  XLEN  write-back data.
- sb_err  out  1  sticky: write-back to a non-zero register whose pending count was 0.

## Operation
- State: regs[1..NREG−1] (XLEN each), cnt[1..NREG−1] (CW each), sb_err. Entry 0 has no storage.
- Reset (reset_n low, asynchronous): all regs = 0, all cnt = 0, sb_err = 0. Held while low. Resulting outputs: rs_data = 0, rs_ready = all ones, iss_ready = 1.
- Issue accept: iss_acc = iss_valid & iss_ready. iss_ready = (iss_rd == 0) | (cnt[iss_rd] != 2^CW−1), combinational.
- Write-back: if wb_valid & wb_rd != 0: regs[wb_rd] ← wb_data at the edge; if cnt[wb_rd] == 0 then sb_err ← 1, cnt stays 0 (no underflow), data still written.
- Counter update per register r ≠ 0, at the edge: +1 if iss_acc & iss_rd==r; −1 if wb_valid & wb_rd==r & cnt[r]≠0; both → unchanged. Never wraps.
- iss_rd == 0: accepted, no counter change. wb_rd == 0: ignored entirely, no sb_err.
- Read port k, a = rs_addr[k]:
  - a == 0: rs_data = 0, rs_ready = 1.
  - wb hit (wb_valid & wb_rd == a) and BYPASS=1: rs_data = wb_data; rs_ready = (cnt[a] ≤ 1).
  - otherwise: rs_data = regs[a]; rs_ready = (cnt[a] == 0).
- Readiness and data reflect state before this cycle's issue; the issuing instruction's own destination never affects same-cycle reads.
- sb_err clears only on reset.

## Timing
- Reads fully combinational from rs_addr, regs, cnt, and (BYPASS=1) wb_*.
- BYPASS=0: written data visible on rs_data the cycle after wb_valid; rs_ready rises the same cycle.
- BYPASS=1: zero-cycle visibility of wb_data and readiness in the wb cycle.
- Issue→pending: cnt increments at the edge of iss_acc; rs_ready for that register falls from the next cycle.
- iss_ready combinational from iss_rd and cnt; no dependence on same-cycle wb (conservative).
- Reset assertion mid-operation drops all pending state immediately; no write in flight completes.

## Test plan
- Reset: reset_n low mid-run with cnt[5]=2 and regs[5]=0xDEADBEEF → immediately rs_data=0, rs_ready all 1, sb_err=0 on port reading x5.
- Basic RAW, BYPASS=1: issue rd=7; next cycle read x7 → rs_ready=0; cycle with wb rd=7 data 0x12345678 → same-cycle rs_data=0x12345678, rs_ready=1; after edge, reads stay 0x12345678, ready=1.
- BYPASS=0: same sequence → wb cycle shows old value 0 and rs_ready=0; next cycle shows 0x12345678, rs_ready=1.
- Multiple outstanding, CW=2: three issues to x3 → iss_ready=0 for iss_rd=3 (x4 still 1); one wb → iss_ready=1, rs_ready(x3)=0; simultaneous issue+wb on x3 → cnt unchanged at 2.
- x0: issue rd=0 and wb rd=0 data 0xFFFFFFFF → reads of x0 return 0, ready=1, sb_err stays 0, iss_ready=1.
- Scoreboard error: wb rd=9 data 0xA5A5A5A5 with cnt[9]=0 → sb_err=1 next cycle and stays set; regs[9]=0xA5A5A5A5; cnt[9] remains 0; subsequent issue to x9 works normally.
